fifo_rwp_ctrl: RTL and testbench

Single-clock FIFO controller that drives a read/write-port block RAM (write port wa/we/di, read port ra/re/do with one-cycle registered read) and presents a first-word-fall-through pop interface. It owns the write/read pointers, the occupancy accounting and a 2-entry output prefetch buffer that absorbs the RAM read latency, so pops can run at one word per clock. The RAM's read data is don't-care when its re is low, so every RAM read the controller issues is captured into the prefetch buffer. Typical use: packet/cell buffering in front of a downstream processing stage, with the RAM instantiated beside it and both RAM clocks tied to clk.

---
 rtl/fifo_rwp_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_fifo_rwp_ctrl.sv | 591 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rwp_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rwp_ctrl
//
// Single-clock FIFO controller for an external block RAM with a separate
// write port (wa/we/di) and a registered read port (ra/re/do, one-cycle
// read latency). The controller owns the write and read pointers, the count
// of words sitting in the RAM, and a 2-entry prefetch buffer that hides the
// RAM read latency. The pop side is first-word-fall-through, so a word can
// be popped every clock.
//
// Parameters
//   ADDRBIT    RAM address width
//   DEPTH      number of RAM words, 2 <= DEPTH <= 2**ADDRBIT (any value)
//   WIDTH      data width
//   AFULL_LVL  afull asserts when lvl >= AFULL_LVL
//   AEMPTY_LVL aempty asserts when lvl <= AEMPTY_LVL
//
// Ports
//   clk      single clock, RAM write and read clocks tie to it
//   rst      synchronous active-high reset, wins over every other input
//   push     write request, pushdat is the word to store
//   full     RAM holds DEPTH words, push is dropped
//   afull    almost full on total level
//   pop      consume the head word, only honoured while popvld
//   popvld   head word present on popdat
//   popdat   head word (registered)
//   aempty   almost empty on total level
//   lvl      total words held: RAM words + in-flight read + buffered words
//   ovf      sticky, push while full
//   udf      sticky, pop while popvld is low
//   clrerr   clears ovf and udf (a new error in the same cycle wins)
//   ramwa/ramwe/ramdi   RAM write port
//   ramra/ramre         RAM read port request
//   ramdo               RAM read data, valid the cycle after ramre
// -----------------------------------------------------------------------------
module fifo_rwp_ctrl #(
    parameter int ADDRBIT    = 9,
    parameter int DEPTH      = 512,
    parameter int WIDTH      = 32,
    parameter int AFULL_LVL  = DEPTH - 8,
    parameter int AEMPTY_LVL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [WIDTH-1:0]   pushdat,
    output logic               full,
    output logic               afull,
    input  logic               pop,
    output logic               popvld,
    output logic [WIDTH-1:0]   popdat,
    output logic               aempty,
    output logic [ADDRBIT+1:0] lvl,
    output logic               ovf,
    output logic               udf,
    input  logic               clrerr,
    output logic [ADDRBIT-1:0] ramwa,
    output logic               ramwe,
    output logic [WIDTH-1:0]   ramdi,
    output logic [ADDRBIT-1:0] ramra,
    output logic               ramre,
    input  logic [WIDTH-1:0]   ramdo
);

    localparam int CW = ADDRBIT + 1;
    localparam int LW = ADDRBIT + 2;

    localparam logic [ADDRBIT-1:0] PTR_LAST = ADDRBIT'(DEPTH - 1);
    localparam logic [CW-1:0]      CNT_FULL = CW'(DEPTH);
    localparam logic [LW-1:0]      AFULL_V  = LW'(AFULL_LVL);
    localparam logic [LW-1:0]      AEMPTY_V = LW'(AEMPTY_LVL);

    // Pointers and RAM occupancy
    logic [ADDRBIT-1:0] wp;
    logic [ADDRBIT-1:0] wp_next;
    logic [ADDRBIT-1:0] rp;
    logic [ADDRBIT-1:0] rp_next;
    logic [CW-1:0]      ramcnt;
    logic [CW-1:0]      ramcnt_next;

    // Read issued in the previous cycle, its data is on ramdo now
    logic               rdpend;

    // Prefetch buffer, buf0 is the head
    logic [WIDTH-1:0]   buf0;
    logic [WIDTH-1:0]   buf0_next;
    logic [WIDTH-1:0]   buf1;
    logic [WIDTH-1:0]   buf1_next;
    logic [1:0]         occ;
    logic [1:0]         occ_next;

    // Error flags
    logic               ovf_next;
    logic               udf_next;

    // Per-cycle events
    logic               pop_fire;
    logic               pop_err;
    logic               push_err;
    logic [2:0]         slots;

    // Status outputs are pure functions of the registered state.
    always_comb begin
        popvld = (occ != 2'd0);
        popdat = buf0;
        full   = (ramcnt == CNT_FULL);
        lvl    = LW'(ramcnt) + LW'(rdpend) + LW'(occ);
        afull  = (lvl >= AFULL_V);
        aempty = (lvl <= AEMPTY_V);
    end

    // RAM request generation. A read is issued only when the buffer will
    // have a free slot for it the cycle its data returns: slots counts the
    // buffer entries already committed (held or in flight) after this
    // cycle's pop. ramcnt only counts words written in earlier cycles, so
    // the read address can never equal the address being written now.
    always_comb begin
        pop_fire = pop & popvld;
        pop_err  = pop & ~popvld;
        push_err = push & full;
        ramwe    = ~rst & push & ~full;
        ramwa    = wp;
        ramdi    = pushdat;
        ramra    = rp;
        slots    = {1'b0, occ} + {2'b00, rdpend} - {2'b00, pop_fire};
        ramre    = ~rst & (ramcnt != '0) & (slots < 3'd2);
    end

    // Pointer advance with explicit wrap so non-power-of-2 depths work.
    always_comb begin
        wp_next = wp;
        rp_next = rp;
        if (ramwe) begin
            wp_next = (wp == PTR_LAST) ? '0 : wp + ADDRBIT'(1);
        end
        if (ramre) begin
            rp_next = (rp == PTR_LAST) ? '0 : rp + ADDRBIT'(1);
        end
        ramcnt_next = ramcnt + CW'(ramwe) - CW'(ramre);
    end

    // Prefetch buffer update. The pop shift is applied first, then the
    // returning RAM word lands in the first free slot after the shift, which
    // keeps order when a capture and a pop happen together. The read-issue
    // rule guarantees at most one entry is occupied after the shift whenever
    // a capture is due.
    always_comb begin
        buf0_next = buf0;
        buf1_next = buf1;
        occ_next  = occ;
        if (pop_fire) begin
            buf0_next = buf1;
            occ_next  = occ - 2'd1;
        end
        if (rdpend) begin
            if (occ_next == 2'd0) begin
                buf0_next = ramdo;
            end else begin
                buf1_next = ramdo;
            end
            occ_next = occ_next + 2'd1;
        end
    end

    // Sticky error flags: clrerr clears, but an error in the same cycle
    // overrides the clear for its own flag.
    always_comb begin
        ovf_next = ovf;
        udf_next = udf;
        if (clrerr) begin
            ovf_next = 1'b0;
            udf_next = 1'b0;
        end
        if (push_err) begin
            ovf_next = 1'b1;
        end
        if (pop_err) begin
            udf_next = 1'b1;
        end
    end

    // State registers. Reset drops everything including a read in flight;
    // the RAM contents themselves are left alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp     <= '0;
            rp     <= '0;
            ramcnt <= '0;
            rdpend <= 1'b0;
            buf0   <= '0;
            buf1   <= '0;
            occ    <= 2'd0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            wp     <= wp_next;
            rp     <= rp_next;
            ramcnt <= ramcnt_next;
            rdpend <= ramre;
            buf0   <= buf0_next;
            buf1   <= buf1_next;
            occ    <= occ_next;
            ovf    <= ovf_next;
            udf    <= udf_next;
        end
    end

endmodule

// File: tb/tb_fifo_rwp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rwp_ctrl
//
// Directed bench for fifo_rwp_ctrl. Two controllers share clk/rst: u_big
// with the default 512-word geometry and u_small with a 5-word RAM so wraps
// on a non-power-of-2 depth come quickly. Each controller has a simple
// behavioural RAM beside it. Inputs change 1 time unit after the rising
// edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_fifo_rwp_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    // u_big signals
    logic        b_push = 1'b0;
    logic [31:0] b_pushdat = '0;
    logic        b_pop = 1'b0;
    logic        b_clrerr = 1'b0;
    logic        b_full, b_afull, b_popvld, b_aempty, b_ovf, b_udf;
    logic [31:0] b_popdat;
    logic [10:0] b_lvl;
    logic [8:0]  b_ramwa, b_ramra;
    logic        b_ramwe, b_ramre;
    logic [31:0] b_ramdi;
    logic [31:0] b_ramdo = '0;
    logic [31:0] b_mem [0:511];

    // u_small signals
    logic        s_push = 1'b0;
    logic [31:0] s_pushdat = '0;
    logic        s_pop = 1'b0;
    logic        s_clrerr = 1'b0;
    logic        s_full, s_afull, s_popvld, s_aempty, s_ovf, s_udf;
    logic [31:0] s_popdat;
    logic [4:0]  s_lvl;
    logic [2:0]  s_ramwa, s_ramra;
    logic        s_ramwe, s_ramre;
    logic [31:0] s_ramdi;
    logic [31:0] s_ramdo = '0;
    logic [31:0] s_mem [0:7];

    // Observers fed from the clock, read back by the tests
    int b_re_count = 0;
    int s_both     = 0;
    int s_coll     = 0;

    // Free-running clock
    always #5 clk = ~clk;

    fifo_rwp_ctrl u_big (
        .clk     (clk),
        .rst     (rst),
        .push    (b_push),
        .pushdat (b_pushdat),
        .full    (b_full),
        .afull   (b_afull),
        .pop     (b_pop),
        .popvld  (b_popvld),
        .popdat  (b_popdat),
        .aempty  (b_aempty),
        .lvl     (b_lvl),
        .ovf     (b_ovf),
        .udf     (b_udf),
        .clrerr  (b_clrerr),
        .ramwa   (b_ramwa),
        .ramwe   (b_ramwe),
        .ramdi   (b_ramdi),
        .ramra   (b_ramra),
        .ramre   (b_ramre),
        .ramdo   (b_ramdo)
    );

    fifo_rwp_ctrl #(
        .ADDRBIT    (3),
        .DEPTH      (5),
        .WIDTH      (32),
        .AFULL_LVL  (4),
        .AEMPTY_LVL (1)
    ) u_small (
        .clk     (clk),
        .rst     (rst),
        .push    (s_push),
        .pushdat (s_pushdat),
        .full    (s_full),
        .afull   (s_afull),
        .pop     (s_pop),
        .popvld  (s_popvld),
        .popdat  (s_popdat),
        .aempty  (s_aempty),
        .lvl     (s_lvl),
        .ovf     (s_ovf),
        .udf     (s_udf),
        .clrerr  (s_clrerr),
        .ramwa   (s_ramwa),
        .ramwe   (s_ramwe),
        .ramdi   (s_ramdi),
        .ramra   (s_ramra),
        .ramre   (s_ramre),
        .ramdo   (s_ramdo)
    );

    // Behavioural RAMs with a one-cycle registered read
    always @(posedge clk) begin
        if (b_ramwe) b_mem[b_ramwa] <= b_ramdi;
        if (b_ramre) b_ramdo <= b_mem[b_ramra];
        if (s_ramwe) s_mem[s_ramwa] <= s_ramdi;
        if (s_ramre) s_ramdo <= s_mem[s_ramra];
    end

    // Count read issues on u_big and same-address collisions on u_small
    always @(negedge clk) begin
        if (rst) b_re_count = 0;
        else if (b_ramre) b_re_count = b_re_count + 1;
        if (s_ramwe && s_ramre) begin
            s_both = s_both + 1;
            if (s_ramwa == s_ramra) s_coll = s_coll + 1;
        end
    end

    // Hard stop in case something never finishes
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no completion, expected finish within 40000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b_push = 1'b0; b_pop = 1'b0; b_clrerr = 1'b0; b_pushdat = '0;
        s_push = 1'b0; s_pop = 1'b0; s_clrerr = 1'b0; s_pushdat = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    // Both controllers come out of reset with every output at its idle value
    task automatic test_reset();
        logic [7:0] flags;
        $display("[TB] test_reset");
        apply_reset();
        flags = {b_popvld, b_full, b_afull, b_ovf, b_udf, b_aempty, b_ramwe, b_ramre};
        vectors++;
        if (flags !== 8'b0000_0100) begin
            miscompares++;
            $display("[TB] FAIL reset_flags_big: got %b, expected 00000100", flags);
        end
        flags = {s_popvld, s_full, s_afull, s_ovf, s_udf, s_aempty, s_ramwe, s_ramre};
        vectors++;
        if (flags !== 8'b0000_0100) begin
            miscompares++;
            $display("[TB] FAIL reset_flags_small: got %b, expected 00000100", flags);
        end
        vectors++;
        if (b_lvl !== 11'd0 || s_lvl !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_lvl: got %0d/%0d, expected 0/0", b_lvl, s_lvl);
        end
        vectors++;
        if (b_popdat !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_popdat: got %h, expected 00000000", b_popdat);
        end
    endtask

    // Three pushes into an empty FIFO. Only two reads go out before both
    // prefetch slots are committed; the third word is fetched once the head
    // is popped, which then drains the rest in order.
    task automatic test_latency();
        int exp_lvl [10];
        int exp_vld [10];
        int exp_dat [10];
        int do_pop  [10];
        logic [31:0] words [3];
        $display("[TB] test_latency");
        exp_lvl = '{0, 1, 2, 3, 3, 3, 2, 2, 1, 0};
        exp_vld = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
        exp_dat = '{0, 0, 0, 'h11, 'h11, 'h11, 'h22, 'h22, 'h33, 0};
        do_pop  = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 0};
        words   = '{32'h11, 32'h22, 32'h33};
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            if (c == 5) begin
                vectors++;
                if (b_re_count !== 2) begin
                    miscompares++;
                    $display("[TB] FAIL lat_reads_before_pop: got %0d, expected 2", b_re_count);
                end
            end
            vectors++;
            if (b_popvld !== (exp_vld[c] != 0)) begin
                miscompares++;
                $display("[TB] FAIL lat_popvld c%0d: got %b, expected %0d", c, b_popvld, exp_vld[c]);
            end
            vectors++;
            if (b_lvl !== 11'(exp_lvl[c])) begin
                miscompares++;
                $display("[TB] FAIL lat_lvl c%0d: got %0d, expected %0d", c, b_lvl, exp_lvl[c]);
            end
            if (exp_vld[c] != 0) begin
                vectors++;
                if (b_popdat !== 32'(exp_dat[c])) begin
                    miscompares++;
                    $display("[TB] FAIL lat_popdat c%0d: got %h, expected %h", c, b_popdat, exp_dat[c]);
                end
            end
            b_push = 1'b0;
            b_pushdat = '0;
            if (c < 3) begin
                b_push = 1'b1;
                b_pushdat = words[c];
            end
            b_pop = (do_pop[c] != 0);
            step();
        end
        idle_inputs();
        vectors++;
        if (b_re_count !== 3) begin
            miscompares++;
            $display("[TB] FAIL lat_reads_total: got %0d, expected 3", b_re_count);
        end
        vectors++;
        if (b_aempty !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL lat_aempty: got %b, expected 1", b_aempty);
        end
    endtask

    // Sustained push+pop starting from two buffered words plus one in RAM,
    // then drain with pop held high.
    task automatic test_back_to_back();
        int exp_out;
        int next_in;
        int guard;
        $display("[TB] test_back_to_back");
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            b_push = 1'b1;
            b_pushdat = 32'(i);
            step();
        end
        b_push = 1'b0;
        step();
        step();
        exp_out = 0;
        next_in = 3;
        for (int i = 0; i < 1000; i++) begin
            vectors++;
            if (b_popvld !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL b2b_popvld i%0d: got %b, expected 1", i, b_popvld);
            end
            vectors++;
            if (b_lvl !== 11'd3) begin
                miscompares++;
                $display("[TB] FAIL b2b_lvl i%0d: got %0d, expected 3", i, b_lvl);
            end
            vectors++;
            if (b_popdat !== 32'(exp_out)) begin
                miscompares++;
                $display("[TB] FAIL b2b_popdat i%0d: got %h, expected %h", i, b_popdat, exp_out);
            end
            b_push = 1'b1;
            b_pushdat = 32'(next_in);
            b_pop = 1'b1;
            next_in++;
            exp_out++;
            step();
        end
        b_push = 1'b0;
        guard = 0;
        while (b_lvl != 0 && guard < 10) begin
            vectors++;
            if (b_popvld !== 1'b1 || b_popdat !== 32'(exp_out)) begin
                miscompares++;
                $display("[TB] FAIL drain_word: got vld=%b dat=%h, expected vld=1 dat=%h", b_popvld, b_popdat, exp_out);
            end
            exp_out++;
            b_pop = 1'b1;
            step();
            guard++;
        end
        b_pop = 1'b0;
        vectors++;
        if (exp_out !== 1003 || b_lvl !== 11'd0) begin
            miscompares++;
            $display("[TB] FAIL drain_end: got next=%0d lvl=%0d, expected next=1003 lvl=0", exp_out, b_lvl);
        end
        vectors++;
        if (b_udf !== 1'b0 || b_ovf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_errors: got ovf=%b udf=%b, expected 0/0", b_ovf, b_udf);
        end
    endtask

    // Pop on empty sets udf; clrerr clears it unless a new pop error coincides
    task automatic test_underflow();
        $display("[TB] test_underflow");
        apply_reset();
        b_pop = 1'b1;
        step();
        b_pop = 1'b0;
        vectors++;
        if (b_udf !== 1'b1 || b_lvl !== 11'd0 || b_popvld !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL udf_set: got udf=%b lvl=%0d vld=%b, expected 1/0/0", b_udf, b_lvl, b_popvld);
        end
        b_clrerr = 1'b1;
        step();
        b_clrerr = 1'b0;
        vectors++;
        if (b_udf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL udf_clear: got %b, expected 0", b_udf);
        end
        b_clrerr = 1'b1;
        b_pop = 1'b1;
        step();
        b_clrerr = 1'b0;
        b_pop = 1'b0;
        vectors++;
        if (b_udf !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL udf_wins_over_clear: got %b, expected 1", b_udf);
        end
        b_clrerr = 1'b1;
        step();
        b_clrerr = 1'b0;
        vectors++;
        if (b_udf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL udf_clear2: got %b, expected 0", b_udf);
        end
    endtask

    // Fill the 5-word controller to DEPTH+2, reject pushes while full
    // (including the cycle a read coincides with full), then drain in order.
    task automatic test_fill();
        int exp;
        int guard;
        $display("[TB] test_fill");
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                vectors++;
                if (s_full !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL fill_full_early: got %b, expected 0", s_full);
                end
            end
            s_push = 1'b1;
            s_pushdat = 32'(i);
            step();
        end
        s_push = 1'b0;
        vectors++;
        if (s_full !== 1'b1 || s_lvl !== 5'd7 || s_afull !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL fill_full: got full=%b lvl=%0d afull=%b, expected 1/7/1", s_full, s_lvl, s_afull);
        end
        s_push = 1'b1;
        s_pushdat = 32'h99;
        #1;
        vectors++;
        if (s_ramwe !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL fill_we_blocked: got %b, expected 0", s_ramwe);
        end
        step();
        s_push = 1'b0;
        vectors++;
        if (s_ovf !== 1'b1 || s_lvl !== 5'd7) begin
            miscompares++;
            $display("[TB] FAIL fill_ovf: got ovf=%b lvl=%0d, expected 1/7", s_ovf, s_lvl);
        end
        s_clrerr = 1'b1;
        step();
        s_clrerr = 1'b0;
        vectors++;
        if (s_ovf !== 1'b0 || s_popdat !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL fill_ovf_clear: got ovf=%b head=%h, expected 0/00000000", s_ovf, s_popdat);
        end
        s_push = 1'b1;
        s_pushdat = 32'h98;
        s_pop = 1'b1;
        #1;
        vectors++;
        if (s_ramwe !== 1'b0 || s_ramre !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL full_and_read: got we=%b re=%b, expected 0/1", s_ramwe, s_ramre);
        end
        step();
        s_push = 1'b0;
        s_pop = 1'b0;
        vectors++;
        if (s_full !== 1'b0 || s_ovf !== 1'b1 || s_lvl !== 5'd6) begin
            miscompares++;
            $display("[TB] FAIL full_drop: got full=%b ovf=%b lvl=%0d, expected 0/1/6", s_full, s_ovf, s_lvl);
        end
        exp = 1;
        guard = 0;
        while (exp < 7 && guard < 40) begin
            s_pop = 1'b0;
            if (s_popvld) begin
                vectors++;
                if (s_popdat !== 32'(exp)) begin
                    miscompares++;
                    $display("[TB] FAIL fill_order: got %h, expected %h", s_popdat, exp);
                end
                exp++;
                s_pop = 1'b1;
            end
            step();
            guard++;
        end
        s_pop = 1'b0;
        vectors++;
        if (exp !== 7 || s_lvl !== 5'd0 || s_udf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL fill_drain_end: got next=%0d lvl=%0d udf=%b, expected 7/0/0", exp, s_lvl, s_udf);
        end
    endtask

    // Random 200-word stream through the 5-word controller with random
    // push and pop gaps; a queue holds the expected order and level.
    task automatic test_wrap();
        logic [31:0] q [$];
        logic [31:0] w;
        int sent;
        int got;
        int guard;
        $display("[TB] test_wrap");
        apply_reset();
        sent = 0;
        got = 0;
        guard = 0;
        while (got < 200 && guard < 4000) begin
            s_push = 1'b0;
            s_pop = 1'b0;
            vectors++;
            if (s_lvl !== 5'(q.size())) begin
                miscompares++;
                $display("[TB] FAIL wrap_lvl: got %0d, expected %0d", s_lvl, q.size());
            end
            if (s_popvld && $urandom_range(0, 2) != 0) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL wrap_spurious_vld: got popvld=1, expected 0");
                end else begin
                    w = q.pop_front();
                    if (s_popdat !== w) begin
                        miscompares++;
                        $display("[TB] FAIL wrap_order word%0d: got %h, expected %h", got, s_popdat, w);
                    end
                end
                got++;
                s_pop = 1'b1;
            end
            if (sent < 200 && !s_full && $urandom_range(0, 3) != 0) begin
                w = $urandom;
                s_push = 1'b1;
                s_pushdat = w;
                q.push_back(w);
                sent++;
            end
            step();
            guard++;
        end
        idle_inputs();
        vectors++;
        if (got !== 200) begin
            miscompares++;
            $display("[TB] FAIL wrap_complete: got %0d words, expected 200", got);
        end
        vectors++;
        if (s_ovf !== 1'b0 || s_udf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wrap_errors: got ovf=%b udf=%b, expected 0/0", s_ovf, s_udf);
        end
        vectors++;
        if (s_coll !== 0 || s_both == 0) begin
            miscompares++;
            $display("[TB] FAIL wrap_addr_collision: got %0d collisions in %0d overlaps, expected 0 in >0", s_coll, s_both);
        end
    endtask

    // Reset with seven words held and a read in flight, then restart cleanly
    task automatic test_reset_midop();
        logic [7:0] flags;
        $display("[TB] test_reset_midop");
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            b_push = 1'b1;
            b_pushdat = 32'hA0 + 32'(i);
            step();
        end
        b_push = 1'b0;
        step();
        step();
        vectors++;
        if (b_lvl !== 11'd7) begin
            miscompares++;
            $display("[TB] FAIL midop_prefill: got %0d, expected 7", b_lvl);
        end
        b_push = 1'b1;
        b_pushdat = 32'hA7;
        b_pop = 1'b1;
        #1;
        vectors++;
        if (b_ramre !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midop_read_issue: got %b, expected 1", b_ramre);
        end
        step();
        vectors++;
        if (b_lvl !== 11'd7) begin
            miscompares++;
            $display("[TB] FAIL midop_inflight_lvl: got %0d, expected 7", b_lvl);
        end
        rst = 1'b1;
        b_push = 1'b1;
        b_pushdat = 32'hEE;
        b_pop = 1'b1;
        #1;
        vectors++;
        if (b_ramwe !== 1'b0 || b_ramre !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midop_rst_priority: got we=%b re=%b, expected 0/0", b_ramwe, b_ramre);
        end
        step();
        rst = 1'b0;
        idle_inputs();
        flags = {b_popvld, b_full, b_afull, b_ovf, b_udf, b_aempty, b_ramwe, b_ramre};
        vectors++;
        if (flags !== 8'b0000_0100 || b_lvl !== 11'd0 || b_popdat !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL midop_reset_state: got flags=%b lvl=%0d dat=%h, expected 00000100/0/00000000", flags, b_lvl, b_popdat);
        end
        step();
        vectors++;
        if (b_popvld !== 1'b0 || b_lvl !== 11'd0) begin
            miscompares++;
            $display("[TB] FAIL midop_inflight_dropped: got vld=%b lvl=%0d, expected 0/0", b_popvld, b_lvl);
        end
        b_push = 1'b1;
        b_pushdat = 32'hAB;
        step();
        b_push = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            vectors++;
            if (b_popvld !== (c == 3)) begin
                miscompares++;
                $display("[TB] FAIL midop_restart_vld t+%0d: got %b, expected %0d", c, b_popvld, (c == 3));
            end
            if (c < 3) step();
        end
        vectors++;
        if (b_popdat !== 32'hAB) begin
            miscompares++;
            $display("[TB] FAIL midop_restart_dat: got %h, expected 000000ab", b_popdat);
        end
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_underflow();
        test_fill();
        test_wrap();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
